// File: rtl/reg_fifo_4x16_pkg.sv
// rtl/reg_fifo_4x16_pkg.sv - shared constants and types for the 4x16 register FIFO
//
// Purpose: the depth, pointer width and data width used by the RTL and the bench,
//          plus the word/pointer/count types and a wrapping pointer increment.
package reg_fifo_4x16_pkg;

  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 3;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  // Power-of-two depth, so the natural overflow of the pointer gives 3->0 wrap.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/reg_fifo_4x16_reg16.sv
// rtl/reg_fifo_4x16_reg16.sv - one 16-bit storage entry with write enable
//
// Purpose: single FIFO storage word, cleared asynchronously by rst.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset, clears the word to zero
//   we_i - write enable; d_i is captured on the rising edge when high
//   d_i  - write data
//   q_o  - stored word
module reg16_ar
  import reg_fifo_4x16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  data_t word_q;
  data_t word_d;

  always_comb begin
    word_d = word_q;
    if (we_i) begin
      word_d = d_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/reg_fifo_4x16.sv
// rtl/reg_fifo_4x16.sv - 4-entry x 16-bit first-word-fall-through register FIFO
//
// Purpose: small FIFO with registered pointers/count, combinational head output
//          and a one-cycle error pulse for rejected requests.
// Ports:
//   clk     - clock
//   rst     - asynchronous active-high reset
//   inData  - write data
//   push    - write request
//   pop     - read request (consumes the head entry)
//   outData - head entry, zero when empty
//   empty   - no valid entries
//   full    - all four entries valid
//   count   - number of valid entries, 0..4
//   err     - registered pulse, high the cycle after a rejected push or pop
module reg_fifo_4x16
  import reg_fifo_4x16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] inData,
  input  logic              push,
  input  logic              pop,
  output logic [DATA_W-1:0] outData,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              err
);

  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  cnt_t  count_q,  count_d;
  logic  err_q,    err_d;

  logic  push_ok;
  logic  pop_ok;
  logic  empty_w;
  logic  full_w;

  data_t            entry_q [DEPTH];
  logic [DEPTH-1:0] entry_we;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == cnt_t'(DEPTH));

  // A pop at full frees the head slot in the same edge, so a push alongside
  // it is still accepted. A pop at empty is never accepted, even with a push.
  assign pop_ok  = pop && !empty_w;
  assign push_ok = push && (!full_w || pop);

  // Storage: only the entry at the tail pointer is written on an accepted push.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign entry_we[i] = push_ok && (wr_ptr_q == ptr_t'(i));

    reg16_ar u_entry (
      .clk  (clk),
      .rst  (rst),
      .we_i (entry_we[i]),
      .d_i  (inData),
      .q_o  (entry_q[i])
    );
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = (push && !push_ok) || (pop && !pop_ok);

    if (push_ok) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Head word falls through directly; forced to zero so stale storage never shows.
  assign outData = empty_w ? '0 : entry_q[rd_ptr_q];
  assign empty   = empty_w;
  assign full    = full_w;
  assign count   = count_q;
  assign err     = err_q;

endmodule

// File: tb/tb_reg_fifo_4x16.sv
// tb/tb_reg_fifo_4x16.sv - self-checking bench for reg_fifo_4x16
module tb_reg_fifo_4x16;
  import reg_fifo_4x16_pkg::*;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] inData;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] outData;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              err;

  int checks;
  int errors;

  logic [DATA_W-1:0] model_q [$];
  logic              exp_err;

  reg_fifo_4x16 dut (
    .clk     (clk),
    .rst     (rst),
    .inData  (inData),
    .push    (push),
    .pop     (pop),
    .outData (outData),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DATA_W-1:0] exp_head;
    exp_head = (model_q.size() != 0) ? model_q[0] : '0;
    check_eq({tag, ".count"}, 32'(count), 32'(model_q.size()));
    check_eq({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
    check_eq({tag, ".full"},  32'(full),  32'(model_q.size() == DEPTH));
    check_eq({tag, ".data"},  32'(outData), 32'(exp_head));
    check_eq({tag, ".err"},   32'(err), 32'(exp_err));
  endtask

  // One clock: apply request, let the edge happen, update the queue model
  // from the FIFO rules, then compare away from the edge.
  task automatic do_cycle(input string tag, input logic p, input logic q, input logic [DATA_W-1:0] d);
    bit pop_acc, push_acc;
    push = p; pop = q; inData = d;
    @(posedge clk);
    pop_acc  = q && (model_q.size() > 0);
    push_acc = p && ((model_q.size() < DEPTH) || q);
    if (pop_acc)  void'(model_q.pop_front());
    if (push_acc) model_q.push_back(d);
    exp_err = (p && !push_acc) || (q && !pop_acc);
    #2;
    check_all(tag);
  endtask

  initial begin
    checks = 0; errors = 0;
    exp_err = 1'b0;
    push = 1'b0; pop = 1'b0; inData = '0;
    rst = 1'b1;
    #1;
    check_all("reset");

    // Requests during reset are ignored.
    push = 1'b1; inData = 16'h7777;
    @(posedge clk); #2;
    check_all("rst_hold");
    push = 1'b0;
    #1 rst = 1'b0;

    // Fill then drain.
    do_cycle("fill0", 1, 0, 16'h1111);
    check_eq("fwft_first", 32'(outData), 32'h1111);
    do_cycle("fill1", 1, 0, 16'h2222);
    do_cycle("fill2", 1, 0, 16'h3333);
    do_cycle("fill3", 1, 0, 16'h4444);
    check_eq("full_flag", 32'(full), 32'h1);
    // Overflow.
    do_cycle("ovf", 1, 0, 16'hDEAD);
    check_eq("ovf_err", 32'(err), 32'h1);
    do_cycle("ovf_idle", 0, 0, 16'h0);
    check_eq("ovf_err_clear", 32'(err), 32'h0);
    for (int i = 0; i < 4; i++) do_cycle("drain", 0, 1, 16'h0);
    check_eq("drained_data", 32'(outData), 32'h0);

    // Underflow.
    do_cycle("udf", 0, 1, 16'h0);
    check_eq("udf_err", 32'(err), 32'h1);
    do_cycle("udf_idle", 0, 0, 16'h0);

    // Push+pop at full.
    do_cycle("f2a", 1, 0, 16'h1111);
    do_cycle("f2b", 1, 0, 16'h2222);
    do_cycle("f2c", 1, 0, 16'h3333);
    do_cycle("f2d", 1, 0, 16'h4444);
    do_cycle("pp_full", 1, 1, 16'h5555);
    check_eq("pp_full_head", 32'(outData), 32'h2222);
    check_eq("pp_full_cnt", 32'(count), 32'd4);
    for (int i = 0; i < 3; i++) do_cycle("pp_drain", 0, 1, 16'h0);
    check_eq("pp_last", 32'(outData), 32'h5555);
    do_cycle("pp_drain_end", 0, 1, 16'h0);

    // Push+pop when empty.
    do_cycle("pp_empty", 1, 1, 16'hABCD);
    check_eq("pp_empty_data", 32'(outData), 32'hABCD);
    check_eq("pp_empty_err", 32'(err), 32'h1);
    do_cycle("pp_empty_pop", 0, 1, 16'h0);

    // Async reset mid-cycle with three entries.
    do_cycle("ar0", 1, 0, 16'hA001);
    do_cycle("ar1", 1, 0, 16'hA002);
    do_cycle("ar2", 1, 0, 16'hA003);
    rst = 1'b1;
    model_q.delete();
    exp_err = 1'b0;
    #1;
    check_all("async_rst");
    @(posedge clk); #3;
    rst = 1'b0;
    do_cycle("post_rst_push", 1, 0, 16'h0F0F);
    check_eq("post_rst_data", 32'(outData), 32'h0F0F);
    do_cycle("post_rst_pop", 0, 1, 16'h0);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      do_cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_fifo_4x16.md
REG_FIFO_4X16 -- requirements
Module: reg_fifo_4x16

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL have port inData, input, 16 bits: the write-side data word.
REQ-004 The block SHALL have port push, input, 1 bit: the write request.
REQ-005 The block SHALL have port pop, input, 1 bit: the read request, consuming the head entry.
REQ-006 The block SHALL have port outData, output, 16 bits: the head entry (first-word-fall-through).
REQ-007 The block SHALL have port empty, output, 1 bit: high when count==0.
REQ-008 The block SHALL have port full, output, 1 bit: high when count==4.
REQ-009 The block SHALL have port count, output, 3 bits: the number of valid entries, 0..4.
REQ-010 The block SHALL have port err, output, 1 bit: a registered one-cycle pulse flagging a rejected request.

Function
REQ-011 Storage SHALL be 4 entries x 16 bits, with 2-bit head (rdPtr) and tail (wrPtr) pointers that wrap 3->0.
REQ-012 A push SHALL be accepted when push && (!full || pop); on acceptance, inData is written at wrPtr and wrPtr increments at the clock edge.
REQ-013 A pop SHALL be accepted when pop && !empty; on acceptance, rdPtr increments at the clock edge.
REQ-014 count SHALL change by +1 for an accepted push alone, -1 for an accepted pop alone, and 0 when both are accepted.
REQ-015 outData SHALL equal entry[rdPtr] combinationally when !empty, and 16'h0000 when empty.
REQ-016 Zero-cycle read latency: a word pushed into an empty FIFO SHALL appear on outData in the cycle after the push edge.
REQ-017 Full with push && pop: both SHALL be accepted, count stays 4, the old head leaves, and the new word is written into the freed slot.
REQ-018 Empty with push && pop: the pop SHALL be rejected, the push accepted, count becomes 1, and err pulses.
REQ-019 A push while full without pop SHALL be ignored: storage, pointers and count are unchanged, and err pulses.
REQ-020 A pop while empty SHALL be ignored, and err pulses.
REQ-021 err SHALL be high exactly for the one cycle after a cycle containing a rejected request; otherwise it is low.
REQ-022 Entries not addressed by an accepted push SHALL hold their value.

Reset
REQ-023 On rst high, independent of clk, the block SHALL clear rdPtr, wrPtr and count to 0, clear err to 0, and clear all storage to 16'h0000.
REQ-024 While rst is high, outputs SHALL be: empty=1, full=0, count=0, outData=0, err=0; push and pop are ignored.
REQ-025 Reset asserted mid-operation SHALL discard all contents, and the first push after rst deasserts SHALL be treated as into an empty FIFO.

Structure
REQ-026 The depth (4), pointer width (2) and data width (16) SHALL be constants in a shared package used by the RTL and the bench.
REQ-027 Each storage entry SHALL be an instance of one sub-module, reg16_ar: a 16-bit register with write enable and asynchronous active-high reset.
REQ-028 Pointer, count and err state SHALL be separate from the storage entries.

Verification
REQ-029 Fill then drain: push 16'h1111, 16'h2222, 16'h3333, 16'h4444 -> full=1, count=4; then 4 pops -> outData 1111,2222,3333,4444 in order, then empty=1, outData=0.
REQ-030 Overflow: at full, push 16'hDEAD without pop -> err=1 for one cycle, count=4, and draining yields 1111..4444 with no DEAD.
REQ-031 Underflow: while empty, pop -> err=1 for one cycle, count=0, outData=0.
REQ-032 Simultaneous push+pop at full: push 16'h5555 with pop -> count=4, head becomes 2222, and 5555 is the last word out.
REQ-033 Simultaneous push+pop when empty with inData 16'hABCD -> count=1, err=1 for one cycle, outData=ABCD next cycle.
REQ-034 Async reset: rst asserted between clock edges with count=3 -> outputs show empty=1, count=0, outData=0 before the next edge; after release, push 16'h0F0F then pop -> outData=0F0F.
